// File: rtl/sudoku_pkg.sv
// Shared constants and state type for the sudoku grid RAM port.
// Grid size, RAM address width and the port FSM encoding.
package sudoku_pkg;

  localparam int CELLS  = 81;
  localparam int ADDR_W = 7;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RD_ISSUE,
    RD_HOLD,
    DONE
  } state_e;

endpackage

// File: rtl/ram_grid_port_if.sv
// Stream and RAM bus bundle for the grid RAM port.
// master = the port block, slave = streams plus RAM beside it.
interface ram_grid_port_if #(
  parameter int Width = 8
) ();
  import sudoku_pkg::*;

  logic              in_valid;
  logic [Width-1:0]  in_data;
  logic              in_ready;

  logic              out_valid;
  logic [Width-1:0]  out_data;
  logic              out_ready;

  logic              RAM_ceb;
  logic              RAM_web;
  logic [ADDR_W-1:0] RAM_A;
  logic [Width-1:0]  RAM_D;
  logic [Width-1:0]  RAM_Q;

  modport master (
    input  in_valid, in_data,
    output in_ready,
    output out_valid, out_data,
    input  out_ready,
    output RAM_ceb, RAM_web, RAM_A, RAM_D,
    input  RAM_Q
  );

  modport slave (
    output in_valid, in_data,
    input  in_ready,
    input  out_valid, out_data,
    output out_ready,
    input  RAM_ceb, RAM_web, RAM_A, RAM_D,
    output RAM_Q
  );

endinterface

// File: rtl/ram_grid_port.sv
// Loads a grid of Cells values into an external RAM from a stream,
// or dumps it back out, one RAM access per cell.
module ram_grid_port
  import sudoku_pkg::*;
#(
  parameter int Width = 8,
  parameter int Cells = CELLS
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_load,
  input  logic            start_dump,
  output logic            busy,
  output logic            done,
  ram_grid_port_if.master bus
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(Cells - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              ceb_q, ceb_d;
  logic              web_q, web_d;
  logic [ADDR_W-1:0] a_q, a_d;
  logic [Width-1:0]  d_q, d_d;
  logic              ov_q, ov_d;
  logic [Width-1:0]  od_q, od_d;
  logic              done_q, done_d;

  // Next state plus next value of every registered output.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ceb_d   = 1'b0;
    web_d   = 1'b1;
    a_d     = a_q;
    d_d     = d_q;
    ov_d    = ov_q;
    od_d    = od_q;
    unique case (state_q)
      IDLE: begin
        if (start_load) begin
          state_d = LOAD;
          cnt_d   = '0;
        end else if (start_dump) begin
          state_d = RD_ISSUE;
          cnt_d   = '0;
          ceb_d   = 1'b1;
          a_d     = '0;
        end
      end
      LOAD: begin
        if (bus.in_valid) begin
          ceb_d = 1'b1;
          web_d = 1'b0;
          a_d   = cnt_q;
          d_d   = bus.in_data;
          if (cnt_q == LAST) begin
            state_d = DONE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      RD_ISSUE: begin
        od_d    = bus.RAM_Q;
        ov_d    = 1'b1;
        state_d = RD_HOLD;
      end
      RD_HOLD: begin
        if (bus.out_ready) begin
          ov_d = 1'b0;
          if (cnt_q == LAST) begin
            state_d = DONE;
          end else begin
            cnt_d   = cnt_q + 1'b1;
            a_d     = cnt_q + 1'b1;
            ceb_d   = 1'b1;
            state_d = RD_ISSUE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    done_d = (state_d == DONE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ceb_q   <= 1'b0;
      web_q   <= 1'b1;
      a_q     <= '0;
      d_q     <= '0;
      ov_q    <= 1'b0;
      od_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ceb_q   <= ceb_d;
      web_q   <= web_d;
      a_q     <= a_d;
      d_q     <= d_d;
      ov_q    <= ov_d;
      od_q    <= od_d;
      done_q  <= done_d;
    end
  end

  assign busy          = (state_q != IDLE);
  assign done          = done_q;
  assign bus.in_ready  = (state_q == LOAD);
  assign bus.out_valid = ov_q;
  assign bus.out_data  = od_q;
  assign bus.RAM_ceb   = ceb_q;
  assign bus.RAM_web   = web_q;
  assign bus.RAM_A     = a_q;
  assign bus.RAM_D     = d_q;

endmodule

// File: doc/ram_grid_port.md
RAM_GRID_PORT -- requirements
Module: ram_grid_port

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk  input  1  rising-edge clock for all block registers; rst  input  1  synchronous active-high reset.
REQ-002 The block SHALL have parameter Width, default 8, the RAM data width.
REQ-003 The block SHALL have parameter Cells, default 81, the number of grid cells (addresses 0..Cells-1).
REQ-004 start_load  input  1  IDLE-only request to write Cells values from the input stream.
REQ-005 start_dump  input  1  IDLE-only request to read Cells values to the output stream.
REQ-006 in_valid / in_data / in_ready  input 1 / input Width / output 1  load stream, transfer when valid&ready.
REQ-007 out_valid / out_data / out_ready  output 1 / output Width / input 1  dump stream, transfer when valid&ready.
REQ-008 busy  output 1  high in every state except IDLE; done  output 1  one-cycle pulse at operation end.
REQ-009 RAM_ceb  output 1  RAM access enable (active high); RAM_web  output 1  write enable (active low); RAM_A  output 7  cell address; RAM_D  output Width  write data; RAM_Q  input Width  read data, which the RAM updates on the falling clk edge of the access cycle.

Function
REQ-010 The FSM SHALL have the states IDLE, LOAD, RD_ISSUE, RD_HOLD and DONE; RAM_ceb, RAM_web, RAM_A, RAM_D, out_valid, out_data and done SHALL be registers.
REQ-011 IDLE: start_load SHALL go to LOAD with cnt=0; otherwise start_dump SHALL go to RD_ISSUE with RAM_ceb=1, RAM_web=1, RAM_A=0; when both are high, load SHALL win.
REQ-012 start_load and start_dump SHALL be ignored outside IDLE.
REQ-013 LOAD: in_ready SHALL be 1 (combinational from state); in all other states in_ready SHALL be 0.
REQ-014 LOAD, in_valid=1 at an edge: the next cycle SHALL drive RAM_ceb=1, RAM_web=0, RAM_A=cnt, RAM_D=in_data, and cnt SHALL increment; in_valid=0 SHALL drive RAM_ceb=0 next cycle.
REQ-015 LOAD, accepting the Cells-th value (cnt=Cells-1): the next state SHALL be DONE, with that final write still driven during the DONE cycle.
REQ-016 RD_ISSUE: at the edge ending the cycle, out_data<=RAM_Q, out_valid<=1, RAM_ceb<=0, and the next state SHALL be RD_HOLD; start_dump to out_valid latency SHALL be 2 cycles.
REQ-017 RD_HOLD, out_ready=0: out_valid and out_data SHALL hold and RAM_ceb SHALL stay 0.
REQ-018 RD_HOLD, out_ready=1: out_valid SHALL go to 0; if cnt=Cells-1 the next state SHALL be DONE, else cnt SHALL increment and the next state SHALL be RD_ISSUE with RAM_A=cnt+1, RAM_ceb=1, RAM_web=1.
REQ-019 DONE SHALL last exactly one cycle with done=1 and SHALL then return to IDLE; the DONE-cycle RAM_ceb SHALL be 0 except for the final load write (REQ-015).
REQ-020 RAM_A SHALL never exceed Cells-1, and cnt SHALL be 7 bits and never wrap.
REQ-021 The block SHALL never assert RAM_ceb with RAM_web=0 outside LOAD or the DONE cycle that follows LOAD.

Reset
REQ-022 rst SHALL force state=IDLE, cnt=0, RAM_ceb=0, RAM_web=1, RAM_A=0, RAM_D=0, out_valid=0, out_data=0, done=0 and busy=0 at the next edge.
REQ-023 rst asserted mid-operation SHALL abort without a done pulse; RAM contents already written SHALL remain valid.

Structure
REQ-024 A shared package sudoku_pkg SHALL hold CELLS=81, ADDR_W=7 and the state enum typedef.
REQ-025 The block SHALL be a single module with no sub-module; the RAM SHALL be instantiated beside it, not inside it.

Verification
REQ-026 The bench SHALL connect the block to the RAM model on the same clk.
REQ-027 Load, continuous in_valid, data 1..81: 81 writes at addresses 0..80 SHALL occur, with done on the cycle after the last accept and busy high for 82 cycles.
REQ-028 Dump after REQ-027 with out_ready=1: out_data SHALL be 1..81 in order, the first out_valid SHALL come 2 cycles after start_dump, and done SHALL pulse once.
REQ-029 Dump with out_ready low for 5 cycles on cell 10: out_data=11 SHALL be held stable with no RAM access, and the sequence SHALL resume correctly.
REQ-030 start_load and start_dump in the same IDLE cycle: LOAD SHALL be entered; start_dump pulsed during LOAD SHALL be ignored.
REQ-031 rst at load cell 40: the block SHALL return to IDLE with no done pulse; a following dump SHALL return cells 0..39 as written and the rest unchanged.
REQ-032 Load with in_valid toggling every other cycle: exactly 81 writes SHALL occur, with RAM_ceb=0 on the idle cycles.
